regfile_writeback: RTL

Writer side of the 32x32 register file write port. Merges results from the single-cycle ALU path and the variable-latency load unit into at most one registered write per cycle on write/wdest/wdata. Keeps a per-register pending scoreboard so issue logic can stall on read-after-write hazards. Sits between the execute/memory units and the register file.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_writeback_wb_load_fifo.sv | 57 +++++
 rtl/regfile_writeback.sv | 120 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: index/data widths and the write-back entry type.
package regfile_pkg;

  localparam int REG_BITS  = 5;
  localparam int REG_WIDTH = 32;
  localparam int REG_COUNT = 2 ** REG_BITS;

  // One pending register-file write: destination index plus data.
  typedef struct packed {
    logic [REG_BITS-1:0]  dest;
    logic [REG_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_wb_load_fifo.sv
// Small FIFO holding load results until the write port is free.
// DEPTH must be a power of two (pointers wrap naturally) and at least 2.
// A push to a full FIFO or a pop from an empty FIFO is ignored.
module wb_load_fifo import regfile_pkg::*; #(
  parameter type entry_t = wb_entry_t,
  parameter int  DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  entry_t                     din,
  output entry_t                     dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset because count gates their use.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-back stage: merges ALU and queued load results into one
// registered write per cycle and tracks outstanding destinations for hazard stalls.
//
// Load handshake: a load result transfers on a rising edge where ld_valid and
// ld_ready are both 1; ld_ready depends only on queue occupancy, never on ld_valid.
// ALU results have no handshake and always win the write port.
module regfile_writeback import regfile_pkg::*; #(
  parameter int REG_BITS      = regfile_pkg::REG_BITS,
  parameter int REG_WIDTH     = regfile_pkg::REG_WIDTH,
  parameter int LQ_DEPTH      = 2,
  parameter bit HARDWIRE_ZERO = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   iss_valid,
  input  logic [REG_BITS-1:0]    iss_dest,
  input  logic                   alu_valid,
  input  logic [REG_BITS-1:0]    alu_dest,
  input  logic [REG_WIDTH-1:0]   alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [REG_BITS-1:0]    ld_dest,
  input  logic [REG_WIDTH-1:0]   ld_data,
  output logic                   write,
  output logic [REG_BITS-1:0]    wdest,
  output logic [REG_WIDTH-1:0]   wdata,
  input  logic [REG_BITS-1:0]    q1,
  input  logic [REG_BITS-1:0]    q2,
  output logic                   q1_busy,
  output logic                   q2_busy,
  output logic [2**REG_BITS-1:0] pending
);

  localparam int NREGS = 2 ** REG_BITS;
  localparam int CW    = $clog2(LQ_DEPTH + 1);

  typedef struct packed {
    logic [REG_BITS-1:0]  dest;
    logic [REG_WIDTH-1:0] data;
  } entry_t;

  entry_t           alu_entry;
  entry_t           ld_entry;
  entry_t           head;
  entry_t           sel;
  logic [CW-1:0]    lq_count;
  logic             lq_full;
  logic             lq_empty;
  logic             lq_push;
  logic             lq_pop;
  logic             sel_valid;
  logic             sel_zero;
  logic [NREGS-1:0] pending_next;

  assign alu_entry = '{dest: alu_dest, data: alu_data};
  assign ld_entry  = '{dest: ld_dest, data: ld_data};

  // Every accepted load is queued, even into an empty queue, so a load
  // reaches the write port no earlier than two edges after acceptance.
  assign ld_ready = !lq_full;
  assign lq_push  = ld_valid && ld_ready;
  assign lq_pop   = !alu_valid && (lq_count != '0);

  wb_load_fifo #(
    .entry_t (entry_t),
    .DEPTH   (LQ_DEPTH)
  ) u_load_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (lq_push),
    .pop   (lq_pop),
    .din   (ld_entry),
    .dout  (head),
    .count (lq_count),
    .full  (lq_full),
    .empty (lq_empty)
  );

  // ALU has fixed priority; the queue head is selected only on ALU-idle cycles.
  assign sel_valid = alu_valid || !lq_empty;
  assign sel       = alu_valid ? alu_entry : head;
  assign sel_zero  = HARDWIRE_ZERO && (sel.dest == '0);

  // Registered write port; a hardwired-zero result still consumes its slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write <= 1'b0;
      wdest <= '0;
      wdata <= '0;
    end else begin
      write <= sel_valid && !flush && !sel_zero;
      if (sel_valid) begin
        wdest <= sel.dest;
        wdata <= sel.data;
      end
    end
  end

  // Next scoreboard: retire the selected dest, then mark the newly issued one
  // (so an issue wins over a same-index retire); flush clears everything.
  always_comb begin
    pending_next = pending;
    if (sel_valid) pending_next[sel.dest] = 1'b0;
    if (iss_valid) pending_next[iss_dest] = 1'b1;
    if (HARDWIRE_ZERO) pending_next[0] = 1'b0;
    if (flush) pending_next = '0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= '0;
    else      pending <= pending_next;
  end

  assign q1_busy = pending[q1];
  assign q2_busy = pending[q2];

endmodule
